// File: rtl/junction_ctrl.sv
// Two-road junction controller with a pedestrian walk phase.
// Transitions are clocked by tick; lamps are decoded from the state register.
module junction_ctrl #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int ORANGE_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 3,
    parameter int CW        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       sens_a,
    input  logic       sens_b,
    input  logic       ped_req,
    output logic       a_red,
    output logic       a_orange,
    output logic       a_green,
    output logic       b_red,
    output logic       b_orange,
    output logic       b_green,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    // state | meaning
    // AG    | road A green, B red
    // AO    | road A orange, B red
    // AR    | all red after A
    // BG    | road B green, A red
    // BO    | road B orange, A red
    // BR    | all red after B
    // PW    | all red, pedestrian walk
    localparam logic [2:0] AG = 3'd0;
    localparam logic [2:0] AO = 3'd1;
    localparam logic [2:0] AR = 3'd2;
    localparam logic [2:0] BG = 3'd3;
    localparam logic [2:0] BO = 3'd4;
    localparam logic [2:0] BR = 3'd5;
    localparam logic [2:0] PW = 3'd6;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic          ped_pend;
    logic          last_road;
    logic          enter_pw;

    logic gmin_done;
    logic gmax_done;
    logic orange_done;
    logic allred_done;
    logic walk_done;

    // Minimum green is a floor: demand arriving after it still ends the green.
    assign gmin_done   = tick && (cnt >= CW'(GREEN_MIN - 1));
    assign gmax_done   = tick && (cnt == CW'(GREEN_MAX - 1));
    assign orange_done = tick && (cnt == CW'(ORANGE_T - 1));
    assign allred_done = tick && (cnt == CW'(ALLRED_T - 1));
    assign walk_done   = tick && (cnt == CW'(WALK_T - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            AG: if (gmax_done || (gmin_done && (sens_b || ped_pend))) state_nxt = AO;
            AO: if (orange_done) state_nxt = AR;
            AR: if (allred_done) state_nxt = ped_pend ? PW : BG;
            BG: if (gmax_done || (gmin_done && (sens_a || ped_pend))) state_nxt = BO;
            BO: if (orange_done) state_nxt = BR;
            BR: if (allred_done) state_nxt = ped_pend ? PW : AG;
            PW: if (walk_done) state_nxt = last_road ? AG : BG;
            default: state_nxt = AG;
        endcase
    end

    assign enter_pw = (state_nxt == PW) && (state != PW);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= AG;
            cnt       <= '0;
            ped_pend  <= 1'b0;
            last_road <= 1'b0;
            ped_ack   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (tick)
                cnt <= cnt + 1'b1;
            // A request on the PW entry edge is kept for the next cycle round.
            ped_pend <= ped_req | (ped_pend & ~enter_pw);
            ped_ack  <= enter_pw;
            if (enter_pw)
                last_road <= (state == BR);
        end
    end

    always_comb begin
        a_red    = 1'b0;
        a_orange = 1'b0;
        a_green  = 1'b0;
        b_red    = 1'b0;
        b_orange = 1'b0;
        b_green  = 1'b0;
        walk     = 1'b0;
        case (state)
            AG: begin a_green  = 1'b1; b_red = 1'b1; end
            AO: begin a_orange = 1'b1; b_red = 1'b1; end
            BG: begin b_green  = 1'b1; a_red = 1'b1; end
            BO: begin b_orange = 1'b1; a_red = 1'b1; end
            AR, BR: begin a_red = 1'b1; b_red = 1'b1; end
            PW: begin a_red = 1'b1; b_red = 1'b1; walk = 1'b1; end
            default: begin a_red = 1'b1; b_red = 1'b1; end
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_junction_ctrl.sv
// Directed and random checks of junction_ctrl against a tick-counting
// reference model, plus literal phase sequences for the key scenarios.
module tb_junction_ctrl;

    localparam int GREEN_MIN = 4;
    localparam int GREEN_MAX = 8;
    localparam int ORANGE_T  = 2;
    localparam int ALLRED_T  = 1;
    localparam int WALK_T    = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    logic sens_a = 1'b0;
    logic sens_b = 1'b0;
    logic ped_req = 1'b0;
    logic a_red, a_orange, a_green, b_red, b_orange, b_green, walk, ped_ack;
    logic [2:0] phase;

    int n_asserts = 0;
    int n_fails = 0;
    bit chk_en = 1'b0;

    junction_ctrl dut (
        .clk(clk), .reset(reset), .tick(tick),
        .sens_a(sens_a), .sens_b(sens_b), .ped_req(ped_req),
        .a_red(a_red), .a_orange(a_orange), .a_green(a_green),
        .b_red(b_red), .b_orange(b_orange), .b_green(b_green),
        .walk(walk), .ped_ack(ped_ack), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_asserts++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: phase number plus ticks spent in it.
    int m_phase = 0;
    int m_ticks = 0;
    bit m_pend = 0;
    bit m_from_b = 0;
    bit m_ack = 0;

    // Lamp vector {a_red,a_orange,a_green,b_red,b_orange,b_green,walk}
    function automatic int lamps_for(input int p);
        case (p)
            0: return 7'b001_100_0;
            1: return 7'b010_100_0;
            2: return 7'b100_100_0;
            3: return 7'b100_001_0;
            4: return 7'b100_010_0;
            5: return 7'b100_100_0;
            6: return 7'b100_100_1;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        int nxt;
        int t;
        if (!reset) begin
            m_phase = 0; m_ticks = 0; m_pend = 0; m_from_b = 0; m_ack = 0;
        end else begin
            nxt = m_phase;
            t = m_ticks + (tick ? 1 : 0);
            if (tick) begin
                case (m_phase)
                    0: if (t == GREEN_MAX || (t >= GREEN_MIN && (sens_b || m_pend))) nxt = 1;
                    1: if (t == ORANGE_T) nxt = 2;
                    2: if (t == ALLRED_T) nxt = m_pend ? 6 : 3;
                    3: if (t == GREEN_MAX || (t >= GREEN_MIN && (sens_a || m_pend))) nxt = 4;
                    4: if (t == ORANGE_T) nxt = 5;
                    5: if (t == ALLRED_T) nxt = m_pend ? 6 : 0;
                    6: if (t == WALK_T) nxt = m_from_b ? 0 : 3;
                    default: nxt = 0;
                endcase
            end
            m_ack = (nxt == 6 && m_phase != 6);
            if (m_ack) begin
                m_from_b = (m_phase == 5);
                m_pend = ped_req;
            end else begin
                m_pend = m_pend | ped_req;
            end
            m_ticks = (nxt != m_phase) ? 0 : t;
            m_phase = nxt;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("phase", int'(phase), m_phase);
            check("lamps", int'({a_red, a_orange, a_green, b_red, b_orange, b_green, walk}),
                  lamps_for(m_phase));
            check("ped_ack", int'(ped_ack), int'(m_ack));
            check("a_one_lamp", int'(a_red) + int'(a_orange) + int'(a_green), 1);
            check("b_one_lamp", int'(b_red) + int'(b_orange) + int'(b_green), 1);
            check("safety_a", int'((a_green || a_orange) && !b_red), 0);
            check("safety_b", int'((b_green || b_orange) && !a_red), 0);
            check("safety_walk", int'(walk && !(a_red && b_red)), 0);
            check("phase_not_7", int'(phase == 3'd7), 0);
        end
    end

    task automatic do_reset();
        reset = 1'b0; tick = 1'b0; sens_a = 1'b0; sens_b = 1'b0; ped_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_phase(input int p, input int lim);
        int k = 0;
        while (int'(phase) != p && k < lim) begin
            @(negedge clk);
            k++;
        end
        check("wait_phase", int'(phase), p);
    endtask

    initial begin
        int exp_s1 [8] = '{0, 0, 0, 0, 1, 1, 2, 3};
        int exp_p  [11] = '{0, 0, 0, 0, 1, 1, 2, 6, 6, 6, 3};
        int n;
        int c1;
        int c2;

        do_reset();
        chk_en = 1'b1;
        check("reset_a_green", int'(a_green), 1);
        check("reset_b_red", int'(b_red), 1);
        check("reset_phase", int'(phase), 0);

        // sens_b demand: minimum green then hand over to B
        tick = 1'b1; sens_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("seq_sens_b", int'(phase), exp_s1[i]);
            @(negedge clk);
        end

        // no demand: both greens run to GREEN_MAX
        do_reset();
        tick = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check("seq_max_a", int'(phase), (i < 8) ? 0 : 1);
            @(negedge clk);
        end
        wait_phase(3, 20);
        n = 0;
        while (phase == 3'd3 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("bg_max_len", n, 8);
        check("bg_then_bo", int'(phase), 4);

        // pedestrian pulse during AG
        do_reset();
        tick = 1'b1; ped_req = 1'b1;
        for (int i = 0; i < 11; i++) begin
            check("seq_ped", int'(phase), exp_p[i]);
            check("seq_ped_walk", int'(walk), (exp_p[i] == 6) ? 1 : 0);
            check("seq_ped_ack", int'(ped_ack), (i == 7) ? 1 : 0);
            @(negedge clk);
            ped_req = 1'b0;
        end

        // reset pulse while in BO
        do_reset();
        tick = 1'b1; sens_b = 1'b1;
        wait_phase(3, 20);
        sens_a = 1'b1;
        wait_phase(4, 20);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("bo_reset_a_green", int'(a_green), 1);
        check("bo_reset_b_red", int'(b_red), 1);
        check("bo_reset_phase", int'(phase), 0);
        check("bo_reset_walk", int'(walk), 0);
        sens_a = 1'b0;

        // tick every third cycle stretches each state threefold
        do_reset();
        sens_b = 1'b1;
        c1 = 0; c2 = 0;
        for (int k = 0; k < 45; k++) begin
            tick = (k % 3 == 0);
            @(negedge clk);
            if (phase == 3'd1) c1++;
            if (phase == 3'd2) c2++;
        end
        check("ao_slow_len", c1, 3 * ORANGE_T);
        check("ar_slow_len", c2, 3 * ALLRED_T);

        // random traffic; the model and invariants are checked every cycle
        do_reset();
        for (int k = 0; k < 30000; k++) begin
            sens_a  = 1'($urandom_range(0, 1));
            sens_b  = 1'($urandom_range(0, 1));
            ped_req = ($urandom_range(0, 15) == 0);
            tick    = 1'($urandom_range(0, 1));
            reset   = ($urandom_range(0, 1999) != 0);
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
